// File: rtl/rpn_calc_datapath.sv
// rpn_calc_datapath: operand/opcode capture, pipelined ALU result and display select.
// Define RPN_FLAGS_EN to register {N,Z,C,V} with the result; otherwise out_Flags is 0.
module rpn_calc_datapath #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_Data,
  input  logic             in_LoadOpA,
  input  logic             in_LoadOpB,
  input  logic             in_LoadOpCode,
  input  logic             in_updateRes,
  input  logic             in_ToDisplaySel,
  input  logic [2:0]       in_Status,
  output logic [WIDTH-1:0] out_OpA,
  output logic [WIDTH-1:0] out_OpB,
  output logic [2:0]       out_OpCode,
  output logic [WIDTH-1:0] out_Result,
  output logic             out_ResultValid,
  output logic [WIDTH-1:0] out_DisplayValue,
  output logic [3:0]       out_Flags
);
  localparam int SW = $clog2(WIDTH);
  logic [WIDTH-1:0] opA, opB, result, aluOut, addRes, subRes, shlRes, shrRes;
  logic [2:0] opCode;
  logic pend, hold, resultValid, capture;
  logic [SW-1:0] shamt;
  assign shamt = opB[SW-1:0];
  assign capture = pend | in_updateRes;
`ifdef RPN_FLAGS_EN
  logic addC, subC, shlC, shrC, carry, ovf;
  logic [3:0] flags;
  assign {addC, addRes} = {1'b0, opA} + {1'b0, opB};
  assign {subC, subRes} = {1'b0, opA} - {1'b0, opB};
  assign {shlC, shlRes} = {1'b0, opA} << shamt;
  assign {shrRes, shrC} = {opA, 1'b0} >> shamt;
  always_comb begin
    carry = opCode == 3'd0 ? addC : opCode == 3'd1 ? subC :
            opCode == 3'd6 ? shlC : opCode == 3'd7 ? shrC : 1'b0;
    ovf = opCode == 3'd0 ? (opA[WIDTH-1] == opB[WIDTH-1]) && (addRes[WIDTH-1] != opA[WIDTH-1]) :
          opCode == 3'd1 ? (opA[WIDTH-1] != opB[WIDTH-1]) && (subRes[WIDTH-1] != opA[WIDTH-1]) : 1'b0;
  end
  always_ff @(posedge clk)
    if (reset) flags <= '0;
    else if (capture) flags <= {aluOut[WIDTH-1], aluOut == '0, carry, ovf};
  assign out_Flags = flags;
`else
  assign addRes = opA + opB;
  assign subRes = opA - opB;
  assign shlRes = opA << shamt;
  assign shrRes = opA >> shamt;
  assign out_Flags = 4'b0000;
`endif
  always_comb begin
    aluOut = '0;
    case (opCode)
      3'd0: aluOut = addRes;
      3'd1: aluOut = subRes;
      3'd2: aluOut = opA & opB;
      3'd3: aluOut = opA | opB;
      3'd4: aluOut = opA ^ opB;
      3'd5: aluOut = ~(opA & opB);
      3'd6: aluOut = shlRes;
      default: aluOut = shrRes;
    endcase
  end
  // A new operand A invalidates any pending or held result; the clear beats same-edge sets.
  always_ff @(posedge clk) begin
    if (reset) begin
      opA <= '0;
      opB <= '0;
      opCode <= '0;
      result <= '0;
      pend <= 1'b0;
      hold <= 1'b0;
      resultValid <= 1'b0;
    end else begin
      if (in_LoadOpA) opA <= in_Data;
      if (in_LoadOpB) opB <= in_Data;
      if (in_LoadOpCode) opCode <= in_Data[2:0];
      if (capture) result <= aluOut;
      pend <= !in_LoadOpA && in_LoadOpCode;
      hold <= !in_LoadOpA && (hold || in_ToDisplaySel);
      resultValid <= !in_LoadOpA && (capture || resultValid);
    end
  end
  always_comb begin
    out_DisplayValue = '0;
    if (hold || in_ToDisplaySel) out_DisplayValue = result;
    else
      case (in_Status)
        3'd0, 3'd2, 3'd4: out_DisplayValue = in_Data;
        3'd1: out_DisplayValue = opA;
        3'd3: out_DisplayValue = opB;
        3'd5: out_DisplayValue = {{(WIDTH-3){1'b0}}, opCode};
        3'd6: out_DisplayValue = result;
        default: out_DisplayValue = '0;
      endcase
  end
  assign out_OpA = opA;
  assign out_OpB = opB;
  assign out_OpCode = opCode;
  assign out_Result = result;
  assign out_ResultValid = resultValid;
endmodule

// File: tb/tb_rpn_calc_datapath.sv
// tb_rpn_calc_datapath: directed plan plus random traffic against an arithmetic reference model.
module tb_rpn_calc_datapath;
  logic clk = 1'b0;
  logic reset;
  logic [15:0] in_Data;
  logic in_LoadOpA, in_LoadOpB, in_LoadOpCode, in_updateRes, in_ToDisplaySel;
  logic [2:0] in_Status;
  logic [15:0] out_OpA, out_OpB, out_Result, out_DisplayValue;
  logic [2:0] out_OpCode;
  logic out_ResultValid;
  logic [3:0] out_Flags;

  rpn_calc_datapath #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_Data(in_Data),
    .in_LoadOpA(in_LoadOpA), .in_LoadOpB(in_LoadOpB), .in_LoadOpCode(in_LoadOpCode),
    .in_updateRes(in_updateRes), .in_ToDisplaySel(in_ToDisplaySel), .in_Status(in_Status),
    .out_OpA(out_OpA), .out_OpB(out_OpB), .out_OpCode(out_OpCode), .out_Result(out_Result),
    .out_ResultValid(out_ResultValid), .out_DisplayValue(out_DisplayValue), .out_Flags(out_Flags)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit started = 0;
  logic [15:0] mA, mB, mRes;
  logic [2:0] mOp;
  logic [3:0] mFlags;
  bit mValid, mPend, mHold;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns {N,Z,C,V, result} computed with plain integer arithmetic.
  function automatic logic [19:0] ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int ia = a;
    int ib = b;
    int sa = $signed(a);
    int sb = $signed(b);
    int s = ib % 16;
    int r = 0;
    bit c = 0;
    bit v = 0;
    logic [15:0] res;
    case (op)
      3'd0: begin r = ia + ib; c = r > 65535; v = (sa + sb > 32767) || (sa + sb < -32768); end
      3'd1: begin r = ia - ib; c = ia < ib; v = (sa - sb > 32767) || (sa - sb < -32768); end
      3'd2: r = ia & ib;
      3'd3: r = ia | ib;
      3'd4: r = ia ^ ib;
      3'd5: r = ~(ia & ib);
      3'd6: begin r = ia << s; c = ((r >> 16) & 1) == 1; end
      default: begin r = ia >> s; c = s > 0 && (((ia >> (s - 1)) & 1) == 1); end
    endcase
    res = r[15:0];
    return {res[15], res == 16'h0, c, v, res};
  endfunction

  function automatic logic [15:0] ref_disp(input logic [15:0] d, input bit tds, input logic [2:0] st);
    if (mHold || tds) return mRes;
    case (st)
      3'd0, 3'd2, 3'd4: return d;
      3'd1: return mA;
      3'd3: return mB;
      3'd5: return {13'b0, mOp};
      3'd6: return mRes;
      default: return 16'h0;
    endcase
  endfunction

  task automatic tick(input bit r, input logic [15:0] d, input bit la, input bit lb, input bit lc,
                      input bit up, input bit tds, input logic [2:0] st);
    logic [19:0] alu;
    bit cap;
    reset = r; in_Data = d; in_LoadOpA = la; in_LoadOpB = lb; in_LoadOpCode = lc;
    in_updateRes = up; in_ToDisplaySel = tds; in_Status = st;
    #1;
    if (started) chk("disp_pre", out_DisplayValue, ref_disp(d, tds, st));
    @(posedge clk);
    if (r) begin
      mA = 0; mB = 0; mOp = 0; mRes = 0; mFlags = 0; mValid = 0; mPend = 0; mHold = 0;
    end else begin
      cap = mPend || up;
      alu = ref_alu(mOp, mA, mB);
      if (cap) begin
        mRes = alu[15:0];
`ifdef RPN_FLAGS_EN
        mFlags = alu[19:16];
`else
        mFlags = 4'b0000;
`endif
      end
      mValid = !la && (cap || mValid);
      mPend = !la && lc;
      mHold = !la && (tds || mHold);
      if (la) mA = d;
      if (lb) mB = d;
      if (lc) mOp = d[2:0];
    end
    #1;
    started = 1;
    chk("opA", out_OpA, mA);
    chk("opB", out_OpB, mB);
    chk("opCode", {13'b0, out_OpCode}, {13'b0, mOp});
    chk("result", out_Result, mRes);
    chk("valid", {15'b0, out_ResultValid}, {15'b0, mValid});
    chk("flags", {12'b0, out_Flags}, {12'b0, mFlags});
    chk("disp_post", out_DisplayValue, ref_disp(d, tds, st));
  endtask

  task automatic chk_flags(input string tag, input logic [3:0] withMacro);
`ifdef RPN_FLAGS_EN
    chk(tag, {12'b0, out_Flags}, {12'b0, withMacro});
`else
    chk(tag, {12'b0, out_Flags}, 16'h0);
`endif
  endtask

  initial begin
    for (int i = 0; i < 3; i++) tick(1, 16'h1234, 0, 0, 0, 0, 0, 3'd0);
    chk("rst_opA", out_OpA, 16'h0);
    chk("rst_result", out_Result, 16'h0);
    chk("rst_valid", {15'b0, out_ResultValid}, 16'h0);
    chk("rst_disp", out_DisplayValue, 16'h1234);
    chk_flags("rst_flags", 4'b0000);
    // ADD overflow, result shown and held
    tick(0, 16'h7FFF, 1, 0, 0, 0, 0, 3'd1);
    tick(0, 16'h0001, 0, 1, 0, 0, 0, 3'd3);
    tick(0, 16'h0000, 0, 0, 1, 0, 0, 3'd5);
    tick(0, 16'h0000, 0, 0, 0, 0, 1, 3'd6);
    chk("add_result", out_Result, 16'h8000);
    chk("add_valid", {15'b0, out_ResultValid}, 16'h1);
    chk_flags("add_flags", 4'b1001);
    tick(0, 16'h1111, 0, 0, 0, 0, 0, 3'd0);
    chk("hold_disp1", out_DisplayValue, 16'h8000);
    tick(0, 16'h2222, 0, 0, 0, 0, 0, 3'd0);
    chk("hold_disp2", out_DisplayValue, 16'h8000);
    // SUB borrow, then LoadOpA clears valid and hold
    tick(0, 16'h0003, 1, 0, 0, 0, 0, 3'd1);
    tick(0, 16'h0005, 0, 1, 0, 0, 0, 3'd3);
    tick(0, 16'h0001, 0, 0, 1, 0, 0, 3'd5);
    tick(0, 16'h0000, 0, 0, 0, 0, 0, 3'd6);
    chk("sub_result", out_Result, 16'hFFFE);
    chk_flags("sub_flags", 4'b1010);
    tick(0, 16'h0010, 1, 0, 0, 0, 0, 3'd0);
    chk("lda_valid", {15'b0, out_ResultValid}, 16'h0);
    chk("lda_opA", out_OpA, 16'h0010);
    chk("lda_disp", out_DisplayValue, 16'h0010);
    // shifts
    tick(0, 16'h8001, 1, 0, 0, 0, 0, 3'd1);
    tick(0, 16'h0001, 0, 1, 0, 0, 0, 3'd3);
    tick(0, 16'h0006, 0, 0, 1, 0, 0, 3'd5);
    tick(0, 16'h0000, 0, 0, 0, 0, 0, 3'd6);
    chk("shl_result", out_Result, 16'h0002);
    chk_flags("shl_flags", 4'b0010);
    tick(0, 16'h0007, 0, 0, 1, 0, 0, 3'd5);
    tick(0, 16'h0000, 0, 0, 0, 0, 0, 3'd6);
    chk("shr_result", out_Result, 16'h4000);
    chk_flags("shr_flags", 4'b0010);
    // display status walk
    tick(0, 16'hAAAA, 1, 0, 0, 0, 0, 3'd0);
    tick(0, 16'h5555, 0, 1, 0, 0, 0, 3'd2);
    tick(0, 16'h0003, 0, 0, 1, 0, 0, 3'd4);
    tick(0, 16'hFFFF, 0, 0, 0, 0, 0, 3'd1);
    chk("st1_disp", out_DisplayValue, 16'hAAAA);
    tick(0, 16'hFFFF, 0, 0, 0, 0, 0, 3'd3);
    chk("st3_disp", out_DisplayValue, 16'h5555);
    tick(0, 16'hFFFF, 0, 0, 0, 0, 0, 3'd5);
    chk("st5_disp", out_DisplayValue, 16'h0003);
    tick(0, 16'h1234, 1, 0, 0, 1, 0, 3'd0);
    chk("lda_upd_valid", {15'b0, out_ResultValid}, 16'h0);
    // reset while a capture is pending
    tick(0, 16'h0000, 0, 0, 1, 0, 0, 3'd0);
    tick(1, 16'h0000, 0, 0, 0, 0, 0, 3'd0);
    chk("rstpend_result", out_Result, 16'h0);
    chk("rstpend_valid", {15'b0, out_ResultValid}, 16'h0);
    tick(0, 16'h0000, 0, 0, 0, 0, 0, 3'd0);
    chk("rstpend_result2", out_Result, 16'h0);
    // random traffic
    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 29) == 0, 16'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 5) == 0, 3'($urandom_range(0, 7)));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rpn_calc_datapath.md
Name: rpn_calc_datapath

Overview:
- Operand/result datapath for the reverse-polish calculator; it is the consumer of the control FSM's load strobes and status code.
- Captures OpA, OpB and OpCode from the switch bus when the controller strobes them.
- Computes the ALU result with a one-cycle pipeline register.
- Selects the value shown on the 7-segment display from controller status plus a sticky result-hold flag.

Parameters:
- WIDTH, 16, operand/result width in bits (≥ 4).

Ports:
- clk  in  1  system clock
- reset  in  1  sync reset, active-high
- in_Data  in  WIDTH  switch bus; operand value, or opcode in bits [2:0]
- in_LoadOpA  in  1  capture in_Data into OpA
- in_LoadOpB  in  1  capture in_Data into OpB
- in_LoadOpCode  in  1  capture in_Data[2:0] into OpCode; arms result pipeline
- in_updateRes  in  1  force re-capture of ALU output into result register
- in_ToDisplaySel  in  1  controller request to show result; sets hold flag
- in_Status  in  3  controller state code 0..6
- out_OpA  out  WIDTH  registered operand A
- out_OpB  out  WIDTH  registered operand B
- out_OpCode  out  3  registered opcode
- out_Result  out  WIDTH  registered result
- out_ResultValid  out  1  result register holds a result for current OpA
- out_DisplayValue  out  WIDTH  value to display driver
- out_Flags  out  4  {N,Z,C,V}, registered with result

Behaviour:
- Reset: every register and output is 0. This covers OpA, OpB, OpCode, Result, ResultValid, Flags, the pend flag and the hold flag. out_DisplayValue then follows the status-0 rule below and equals in_Data.
- Load strobes: single-cycle, sampled at the rising edge. Simultaneous strobes each load their own register independently.
- ALU: combinational on the registered OpA/OpB/OpCode. Result is truncated to WIDTH.
  - 0 ADD
  - 1 SUB (A−B)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NAND
  - 6 SHL (A << B[$clog2(WIDTH)-1:0])
  - 7 SHR (logical, same shift amount)
- Pipeline: in_LoadOpCode high in cycle k sets pend at the end of k. The result register captures ALU output at the end of k+1, pend clears, and ResultValid=1 from cycle k+2.
- in_updateRes: also captures at that edge and sets ResultValid.
- ResultValid clear: in_LoadOpA clears ResultValid and pend. The clear wins over a same-cycle capture. Result and Flags still load at that edge, computed from pre-edge OpA.
- Hold flag: set when in_ToDisplaySel=1; cleared by in_LoadOpA. If both occur in the same cycle, the clear wins.
- Display mux, evaluated in priority order:
  - hold=1 or in_ToDisplaySel=1 → Result
  - status 0, 2, 4 → in_Data (live entry)
  - status 1 → OpA
  - status 3 → OpB
  - status 5 → zero-extended OpCode
  - status 6 → Result
  - status 7 → 0
- Undo by the controller changes only in_Status. Registers keep their values; a subsequent load overwrites them.
- Reset mid-pipeline (pend=1): pend is discarded and no capture occurs.

Optional Feature:
- Macro RPN_FLAGS_EN.
- Defined: out_Flags is captured alongside Result.
  - N = result MSB.
  - Z = result==0.
  - C = carry-out for ADD; borrow (A<B unsigned) for SUB; last bit shifted out for SHL/SHR; 0 otherwise.
  - V = signed overflow for ADD/SUB; 0 otherwise.
- Undefined: out_Flags is tied to 4'b0000 and the flag logic is absent.

Test Plan (WIDTH=16):
- Reset, then hold reset 3 cycles with in_Data=16'h1234, status 0 → all registers 0, out_DisplayValue=16'h1234, ResultValid=0.
- Load A=16'h7FFF, B=16'h0001, OpCode=0 (k), ToDisplaySel in k+1 → out_Result=16'h8000 and ResultValid=1 from k+2. Display=16'h8000 and stays there with status 0 until the next LoadOpA. With macro: Flags N=1, Z=0, C=0, V=1.
- A=16'h0003, B=16'h0005, OpCode=1 → Result=16'hFFFE. With macro: N=1, C=1, V=0. Then LoadOpA with in_Data=16'h0010 → ResultValid=0, hold cleared, OpA=16'h0010.
- A=16'h8001, B=16'h0001, OpCode=6 → Result=16'h0002 (C=1 with macro). Then OpCode=7 on the same operands → Result=16'h4000, C=1.
- Status sequence 1,3,5 with OpA=16'hAAAA, OpB=16'h5555, OpCode=3 → display shows 16'hAAAA, 16'h5555, 16'h0003 in turn. LoadOpA and updateRes asserted in the same cycle → ResultValid stays 0.
- Assert reset in cycle k+1 after LoadOpCode in cycle k → Result remains 0 and ResultValid=0 at k+2. Without macro, out_Flags=0 throughout every test.
